// File: rtl/counter_updown_mod_if.sv
// Control/status bundle for counter_updown_mod: step controls and load in, count and wrap out.
interface counter_updown_mod_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] counter;
  logic             wrap;

  modport master (
    output enable, up_down, load, load_value,
    input  counter, wrap
  );

  modport slave (
    input  enable, up_down, load, load_value,
    output counter, wrap
  );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with prescaled enable, synchronous clamped load and a registered wrap pulse.
// Build option COUNTER_SATURATE_EN: counter holds at the range ends and wrap flags each blocked step.
module counter_updown_mod #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  counter_updown_mod_if.slave bus
);
  localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             wrap_q, wrap_d;
  logic             step;

  always_comb begin
    count_d = count_q;
    ps_d    = ps_q;
    wrap_d  = 1'b0;
    step    = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_value > CNT_MAX) ? CNT_MAX : bus.load_value;
      ps_d    = '0;
    end else if (bus.enable) begin
      step = (ps_q == PS_LAST);
      ps_d = step ? '0 : ps_q + PS_W'(1);
      if (step) begin
        // Range ends are compared explicitly so a non-power-of-two MODULUS wraps correctly.
        if (bus.up_down) begin
          if (count_q == CNT_MAX) begin
            wrap_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
            count_d = count_q;
`else
            count_d = '0;
`endif
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            wrap_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
            count_d = count_q;
`else
            count_d = CNT_MAX;
`endif
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
      ps_q    <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ps_q    <= ps_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.counter = count_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: default, MODULUS=10 and PRESCALE=4 instances.
module tb_counter_updown_mod;
`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_a, reset_m, reset_p;

  counter_updown_mod_if #(.WIDTH(8)) bus_a ();
  counter_updown_mod_if #(.WIDTH(8)) bus_m ();
  counter_updown_mod_if #(.WIDTH(8)) bus_p ();

  counter_updown_mod #(.WIDTH(8), .MODULUS(256), .PRESCALE(1)) dut_a (
    .clock_i(clock), .reset_i(reset_a), .bus(bus_a)
  );
  counter_updown_mod #(.WIDTH(8), .MODULUS(10), .PRESCALE(1)) dut_m (
    .clock_i(clock), .reset_i(reset_m), .bus(bus_m)
  );
  counter_updown_mod #(.WIDTH(8), .MODULUS(256), .PRESCALE(4)) dut_p (
    .clock_i(clock), .reset_i(reset_p), .bus(bus_p)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int wraps;
  int wrap_bad;

  initial begin
    reset_a = 1'b1; reset_m = 1'b1; reset_p = 1'b1;
    bus_a.enable = 1'b1; bus_a.up_down = 1'b1; bus_a.load = 1'b0; bus_a.load_value = '0;
    bus_m.enable = 1'b0; bus_m.up_down = 1'b1; bus_m.load = 1'b0; bus_m.load_value = '0;
    bus_p.enable = 1'b0; bus_p.up_down = 1'b1; bus_p.load = 1'b0; bus_p.load_value = '0;

    // Reset held with enable high
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("rst_cnt", 32'(bus_a.counter), 0);
      check_val("rst_wrap", 32'(bus_a.wrap), 0);
    end
    check_val("rst_m_cnt", 32'(bus_m.counter), 0);
    check_val("rst_p_cnt", 32'(bus_p.counter), 0);

    // 300 up steps on the default instance
    reset_a = 1'b0; reset_m = 1'b0; reset_p = 1'b0;
    wraps = 0; wrap_bad = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus_a.wrap) begin
        wraps++;
        if (!SAT && bus_a.counter != 8'd0) wrap_bad++;
      end
      if (i == 255) begin
        check_val("up255_cnt", 32'(bus_a.counter), 255);
        check_val("up255_wrap", 32'(bus_a.wrap), 0);
      end
      if (i == 256) check_val("up256_wrap", 32'(bus_a.wrap), 1);
    end
    check_val("up300_cnt", 32'(bus_a.counter), SAT ? 255 : 44);
    check_val("up300_wraps", 32'(wraps), SAT ? 45 : 1);
    check_val("wrap_at_zero", 32'(wrap_bad), 0);

    // Hold with enable low: wrap clears, count stays
    bus_a.enable = 1'b0;
    tick();
    check_val("hold_cnt", 32'(bus_a.counter), SAT ? 255 : 44);
    check_val("hold_wrap", 32'(bus_a.wrap), 0);
    tick();
    check_val("hold2_cnt", 32'(bus_a.counter), SAT ? 255 : 44);

    // Load beats enable
    bus_a.enable = 1'b1; bus_a.load = 1'b1; bus_a.load_value = 8'hC8;
    tick();
    check_val("load_c8", 32'(bus_a.counter), 200);
    check_val("load_wrap", 32'(bus_a.wrap), 0);

    // Reset mid-count at 100, then resume
    bus_a.load_value = 8'd97;
    tick();
    bus_a.load = 1'b0;
    tick(); tick(); tick();
    check_val("at100", 32'(bus_a.counter), 100);
    reset_a = 1'b1;
    tick();
    check_val("midrst_cnt", 32'(bus_a.counter), 0);
    reset_a = 1'b0;
    tick();
    check_val("resume1", 32'(bus_a.counter), 1);
    tick();
    check_val("resume2", 32'(bus_a.counter), 2);

    // Top end behaviour
    bus_a.load = 1'b1; bus_a.load_value = 8'd254;
    tick();
    bus_a.load = 1'b0;
    tick();
    check_val("top_cnt", 32'(bus_a.counter), 255);
    check_val("top_wrap", 32'(bus_a.wrap), 0);
    tick();
    check_val("top_step_cnt", 32'(bus_a.counter), SAT ? 255 : 0);
    check_val("top_step_wrap", 32'(bus_a.wrap), 1);
    tick();
    check_val("top_next_cnt", 32'(bus_a.counter), SAT ? 255 : 1);
    check_val("top_next_wrap", 32'(bus_a.wrap), SAT ? 1 : 0);

    // Down step at 0 on the default instance
    bus_a.load = 1'b1; bus_a.load_value = 8'd0;
    tick();
    bus_a.load = 1'b0; bus_a.up_down = 1'b0;
    tick();
    check_val("dn0_cnt", 32'(bus_a.counter), SAT ? 0 : 255);
    check_val("dn0_wrap", 32'(bus_a.wrap), 1);
    bus_a.enable = 1'b0;

    // MODULUS=10 instance
    bus_m.enable = 1'b1; bus_m.up_down = 1'b0;
    tick();
    check_val("m10_dn_cnt", 32'(bus_m.counter), SAT ? 0 : 9);
    check_val("m10_dn_wrap", 32'(bus_m.wrap), 1);
    tick();
    check_val("m10_dn2_cnt", 32'(bus_m.counter), SAT ? 0 : 8);
    check_val("m10_dn2_wrap", 32'(bus_m.wrap), SAT ? 1 : 0);
    bus_m.load = 1'b1; bus_m.load_value = 8'hFF;
    tick();
    check_val("m10_clamp", 32'(bus_m.counter), 9);
    check_val("m10_clamp_wrap", 32'(bus_m.wrap), 0);
    bus_m.load_value = 8'd10;
    tick();
    check_val("m10_clamp10", 32'(bus_m.counter), 9);
    bus_m.load_value = 8'd5;
    tick();
    check_val("m10_load5", 32'(bus_m.counter), 5);
    bus_m.load_value = 8'd9;
    tick();
    bus_m.load = 1'b0; bus_m.up_down = 1'b1;
    tick();
    check_val("m10_up_cnt", 32'(bus_m.counter), SAT ? 9 : 0);
    check_val("m10_up_wrap", 32'(bus_m.wrap), 1);
    tick();
    check_val("m10_up2_cnt", 32'(bus_m.counter), SAT ? 9 : 1);
    bus_m.enable = 1'b0;

    // PRESCALE=4 instance: steps land on enabled cycles 4, 8, 12
    bus_p.enable = 1'b1; bus_p.up_down = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) check_val("ps_c3", 32'(bus_p.counter), 0);
      if (i == 4) check_val("ps_c4", 32'(bus_p.counter), 1);
    end
    check_val("ps_c6", 32'(bus_p.counter), 1);
    bus_p.enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_val("ps_paused", 32'(bus_p.counter), 1);
    bus_p.enable = 1'b1;
    bus_p.up_down = 1'b0;
    tick();
    check_val("ps_c7", 32'(bus_p.counter), 1);
    bus_p.up_down = 1'b1;
    tick();
    check_val("ps_c8", 32'(bus_p.counter), 2);
    for (int i = 0; i < 4; i++) tick();
    check_val("ps_c12", 32'(bus_p.counter), 3);
    bus_p.load = 1'b1; bus_p.load_value = 8'd7;
    tick();
    bus_p.load = 1'b0;
    tick(); tick(); tick();
    check_val("ps_ld_c3", 32'(bus_p.counter), 7);
    tick();
    check_val("ps_ld_c4", 32'(bus_p.counter), 8);
    bus_p.enable = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
